// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle instruction control FSM. Walks fetch, decode,
// per-class operand/memory/stack sequences and interrupt entry, and emits one
// datapath transfer command plus side strobes per cycle. Memory states stall
// until the memory reports ready.
module control_sequencer #(
    parameter  int STACK_DEPTH = 16,
    parameter  int IRQ_EN      = 1,
    localparam int LVL_W       = $clog2(STACK_DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [2:0]       i_op_class,
    input  logic             i_mem_ready,
    input  logic             i_irq,
    output logic [3:0]       o_transfer_cmd,
    output logic             o_mem_req,
    output logic             o_inc_pc,
    output logic             o_alu_calculate,
    output logic [1:0]       o_inc_dec_sp,
    output logic [LVL_W-1:0] o_stack_level,
    output logic             o_load_vector,
    output logic             o_irq_ack,
    output logic             o_stack_fault,
    output logic             o_halted
);

    // Datapath transfer commands
    localparam logic [3:0] CMD_NONE   = 4'h0;
    localparam logic [3:0] CMD_MA_PC  = 4'h1;
    localparam logic [3:0] CMD_MD_MEM = 4'h2;
    localparam logic [3:0] CMD_IR_MD  = 4'h3;
    localparam logic [3:0] CMD_MA_MD  = 4'h4;
    localparam logic [3:0] CMD_A_MD   = 4'h5;
    localparam logic [3:0] CMD_MA_SP  = 4'h7;
    localparam logic [3:0] CMD_MD_A   = 4'h8;
    localparam logic [3:0] CMD_MEM_MD = 4'h9;
    localparam logic [3:0] CMD_A_R    = 4'hA;
    localparam logic [3:0] CMD_PC_MD  = 4'hB;
    localparam logic [3:0] CMD_MD_PC  = 4'hF;

    // Stack pointer strobes: up = SP increment (pop), down = SP decrement (push)
    localparam logic [1:0] SP_HOLD = 2'b00;
    localparam logic [1:0] SP_UP   = 2'b01;
    localparam logic [1:0] SP_DOWN = 2'b10;

    // Decoded instruction classes
    localparam logic [2:0] CLS_NOP   = 3'd0;
    localparam logic [2:0] CLS_ALU   = 3'd1;
    localparam logic [2:0] CLS_LOAD  = 3'd2;
    localparam logic [2:0] CLS_STORE = 3'd3;
    localparam logic [2:0] CLS_PUSH  = 3'd4;
    localparam logic [2:0] CLS_POP   = 3'd5;
    localparam logic [2:0] CLS_JMP   = 3'd6;
    localparam logic [2:0] CLS_HALT  = 3'd7;

    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(STACK_DEPTH);

    typedef enum logic [4:0] {
        ST_RESET, ST_FETCH_MA, ST_FETCH_RD, ST_DECODE, ST_DISPATCH,
        ST_OP_MA, ST_OP_RD, ST_ALU, ST_WB_R, ST_ADDR, ST_MEM_RD, ST_WB_MD,
        ST_MD_A, ST_MEM_WR, ST_JMP, ST_SP_DEC, ST_SP_MA,
        ST_IRQ_DEC, ST_IRQ_MA, ST_IRQ_MD, ST_IRQ_WR, ST_IRQ_VEC, ST_HALT
    } state_t;

    state_t           state;
    state_t           state_next;
    state_t           end_next;
    logic [2:0]       op_cls;
    logic [LVL_W-1:0] level;
    logic             fault;
    logic             set_fault;
    logic             irq_prev;
    logic             irq_pending;
    logic             irq_edge;
    logic             stack_full;
    logic             stack_empty;

    assign irq_edge    = (IRQ_EN != 0) && i_irq && !irq_prev;
    assign stack_full  = (level == LVL_FULL);
    assign stack_empty = (level == '0);

    // Instruction end: take a pending interrupt only when the stack has room,
    // otherwise leave it pending and fetch the next instruction.
    assign end_next = ((IRQ_EN != 0) && irq_pending && !stack_full) ? ST_IRQ_DEC
                                                                    : ST_FETCH_MA;

    // State register, latched instruction class and sticky fault
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of its sources, independent of block ordering.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= ST_RESET;
            op_cls <= CLS_NOP;
            fault  <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_DISPATCH) op_cls <= i_op_class;
            if (set_fault)            fault  <= 1'b1;
        end
    end

    // Stack occupancy follows the SP strobe issued this cycle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            level <= '0;
        end else begin
            case (o_inc_dec_sp)
                SP_DOWN: level <= level + LVL_W'(1);
                SP_UP:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Interrupt edge capture; an edge arriving in IRQ_VEC re-arms the request
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            irq_prev    <= 1'b0;
            irq_pending <= 1'b0;
        end else begin
            irq_prev    <= i_irq;
            irq_pending <= irq_edge || (irq_pending && (state != ST_IRQ_VEC));
        end
    end

    // Next-state and per-state outputs
    // NOTE: every output and next-state gets a default first so no path through
    // the case statement leaves a variable unassigned (which would infer a latch).
    always_comb begin
        state_next      = state;
        o_transfer_cmd  = CMD_NONE;
        o_mem_req       = 1'b0;
        o_inc_pc        = 1'b0;
        o_alu_calculate = 1'b0;
        o_inc_dec_sp    = SP_HOLD;
        o_load_vector   = 1'b0;
        o_irq_ack       = 1'b0;
        o_halted        = 1'b0;
        set_fault       = 1'b0;

        case (state)
            ST_RESET:    state_next = ST_FETCH_MA;
            ST_FETCH_MA: begin
                o_transfer_cmd = CMD_MA_PC;
                state_next     = ST_FETCH_RD;
            end
            ST_FETCH_RD: begin
                o_transfer_cmd = CMD_MD_MEM;
                o_mem_req      = 1'b1;
                if (i_mem_ready) begin
                    o_inc_pc   = 1'b1;
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                o_transfer_cmd = CMD_IR_MD;
                state_next     = ST_DISPATCH;
            end
            ST_DISPATCH: begin
                case (i_op_class)
                    CLS_NOP:   state_next = end_next;
                    CLS_ALU, CLS_LOAD, CLS_STORE, CLS_JMP:
                               state_next = ST_OP_MA;
                    CLS_PUSH: begin
                        if (stack_full) begin
                            set_fault  = 1'b1;
                            state_next = ST_HALT;
                        end else begin
                            state_next = ST_SP_DEC;
                        end
                    end
                    CLS_POP: begin
                        if (stack_empty) begin
                            set_fault  = 1'b1;
                            state_next = ST_HALT;
                        end else begin
                            state_next = ST_SP_MA;
                        end
                    end
                    CLS_HALT:  state_next = ST_HALT;
                    default:   state_next = ST_HALT;
                endcase
            end
            ST_OP_MA: begin
                o_transfer_cmd = CMD_MA_PC;
                state_next     = ST_OP_RD;
            end
            ST_OP_RD: begin
                o_transfer_cmd = CMD_MD_MEM;
                o_mem_req      = 1'b1;
                if (i_mem_ready) begin
                    o_inc_pc = 1'b1;
                    case (op_cls)
                        CLS_ALU:             state_next = ST_ALU;
                        CLS_LOAD, CLS_STORE: state_next = ST_ADDR;
                        default:             state_next = ST_JMP;
                    endcase
                end
            end
            ST_ALU: begin
                o_alu_calculate = 1'b1;
                state_next      = ST_WB_R;
            end
            ST_WB_R: begin
                o_transfer_cmd = CMD_A_R;
                state_next     = end_next;
            end
            ST_ADDR: begin
                o_transfer_cmd = CMD_MA_MD;
                state_next     = (op_cls == CLS_STORE) ? ST_MD_A : ST_MEM_RD;
            end
            ST_MEM_RD: begin
                o_transfer_cmd = CMD_MD_MEM;
                o_mem_req      = 1'b1;
                if (i_mem_ready) begin
                    // Popping: release the stack slot in the cycle the read lands
                    if (op_cls == CLS_POP) o_inc_dec_sp = SP_UP;
                    state_next = ST_WB_MD;
                end
            end
            ST_WB_MD: begin
                o_transfer_cmd = CMD_A_MD;
                state_next     = end_next;
            end
            ST_MD_A: begin
                o_transfer_cmd = CMD_MD_A;
                state_next     = ST_MEM_WR;
            end
            ST_MEM_WR: begin
                o_transfer_cmd = CMD_MEM_MD;
                o_mem_req      = 1'b1;
                if (i_mem_ready) state_next = end_next;
            end
            ST_JMP: begin
                o_transfer_cmd = CMD_PC_MD;
                state_next     = end_next;
            end
            ST_SP_DEC: begin
                o_inc_dec_sp = SP_DOWN;
                state_next   = ST_SP_MA;
            end
            ST_SP_MA: begin
                o_transfer_cmd = CMD_MA_SP;
                state_next     = (op_cls == CLS_PUSH) ? ST_MD_A : ST_MEM_RD;
            end
            ST_IRQ_DEC: begin
                o_inc_dec_sp = SP_DOWN;
                state_next   = ST_IRQ_MA;
            end
            ST_IRQ_MA: begin
                o_transfer_cmd = CMD_MA_SP;
                state_next     = ST_IRQ_MD;
            end
            ST_IRQ_MD: begin
                o_transfer_cmd = CMD_MD_PC;
                state_next     = ST_IRQ_WR;
            end
            ST_IRQ_WR: begin
                o_transfer_cmd = CMD_MEM_MD;
                o_mem_req      = 1'b1;
                if (i_mem_ready) state_next = ST_IRQ_VEC;
            end
            ST_IRQ_VEC: begin
                o_load_vector = 1'b1;
                o_irq_ack     = 1'b1;
                state_next    = ST_FETCH_MA;
            end
            // Only reset leaves HALT
            ST_HALT:     o_halted = 1'b1;
            default:     state_next = ST_RESET;
        endcase
    end

    assign o_stack_level = level;
    assign o_stack_fault = fault;

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameter STACK_DEPTH, default 16, maximum number of stack entries (power of two, >=2).
REQ-002 SHALL have parameter IRQ_EN, default 1, 1 = interrupt entry sequence implemented, 0 = i_irq ignored.
REQ-003 SHALL have local parameter LVL_W = clog2(STACK_DEPTH)+1.
REQ-004 i_clk  in  1  single clock; all state changes on rising edge.
REQ-005 i_rst  in  1  reset, synchronous, active-high.
REQ-006 i_op_class  in  3  decoded class of current IR (0 NOP, 1 ALU-imm, 2 LOAD, 3 STORE, 4 PUSH, 5 POP, 6 JMP, 7 HALT); valid from the cycle after DECODE.
REQ-007 i_mem_ready  in  1  memory completes the requested access in the cycle it is high.
REQ-008 i_irq  in  1  interrupt request, level; rising edge latched.
REQ-009 o_transfer_cmd  out  4  datapath transfer (0 none, 1 MA<-PC, 2 MD<-M[MA], 3 IR<-MD, 4 MA<-MD, 5 A<-MD, 7 MA<-SP, 8 MD<-A, 9 M[MA]<-MD, A A<-R, B PC<-MD, F MD<-PC).
REQ-010 o_mem_req  out  1  memory access pending (cmd 2 or 9 states).
REQ-011 o_inc_pc  out  1  PC increment strobe.
REQ-012 o_alu_calculate  out  1  ALU evaluate strobe.
REQ-013 o_inc_dec_sp  out  2  01 = SP increment, 10 = SP decrement, 00 = hold.
REQ-014 o_stack_level  out  LVL_W  current stack occupancy.
REQ-015 o_load_vector  out  1  PC <- interrupt vector strobe.
REQ-016 o_irq_ack  out  1  one-cycle interrupt acknowledge.
REQ-017 o_stack_fault  out  1  sticky stack overflow/underflow flag.
REQ-018 o_halted  out  1  high while in HALT.

Function
REQ-019 States SHALL be: RESET, FETCH_MA(1), FETCH_RD(2,req), DECODE(3), DISPATCH(0), OP_MA(1), OP_RD(2,req), ALU, WB_R(A), ADDR(4), MEM_RD(2,req), WB_MD(5), MD_A(8), MEM_WR(9,req), JMP(B), SP_DEC, SP_MA(7), IRQ_DEC, IRQ_MA(7), IRQ_MD(F), IRQ_WR(9,req), IRQ_VEC, HALT; bracket = o_transfer_cmd, all others 0.
REQ-020 Flow: RESET->FETCH_MA->FETCH_RD->DECODE->DISPATCH.
REQ-021 DISPATCH: class 0->END; 1,2,3,6->OP_MA->OP_RD then 1:ALU->WB_R->END, 2:ADDR->MEM_RD->WB_MD->END, 3:ADDR->MD_A->MEM_WR->END, 6:JMP->END.
REQ-022 DISPATCH class 4 (PUSH): level==STACK_DEPTH -> set fault, HALT; else SP_DEC(o_inc_dec_sp=10, level+1)->SP_MA->MD_A->MEM_WR->END.
REQ-023 DISPATCH class 5 (POP): level==0 -> set fault, HALT; else SP_MA->MEM_RD(o_inc_dec_sp=01 and level-1 in ready cycle)->WB_MD->END.
REQ-024 DISPATCH class 7 -> HALT; HALT SHALL persist until i_rst, all strobes 0, o_halted=1.
REQ-025 "END" SHALL mean: if IRQ_EN and irq_pending and level<STACK_DEPTH -> IRQ_DEC, else FETCH_MA.
REQ-026 Interrupt: IRQ_DEC(dec, level+1)->IRQ_MA->IRQ_MD->IRQ_WR->IRQ_VEC(o_load_vector=1, o_irq_ack=1)->FETCH_MA.
REQ-027 irq_pending SHALL set on a 0->1 edge of i_irq (registered previous value) and clear in IRQ_VEC; an edge coincident with IRQ_VEC SHALL keep it set.
REQ-028 irq_pending with level==STACK_DEPTH SHALL be deferred (remain set), not faulted.
REQ-029 Any req state SHALL hold state and outputs while i_mem_ready=0 and advance on the edge where i_mem_ready=1.
REQ-030 o_inc_pc SHALL assert only in FETCH_RD/OP_RD cycles with i_mem_ready=1 (exactly once per fetched byte).
REQ-031 o_stack_level SHALL never exceed STACK_DEPTH nor go below 0.
REQ-032 Minimum latency: NOP 4 cycles, ALU-imm 8, LOAD/STORE 9, PUSH 8, POP 7, JMP 7, interrupt entry +5, each plus memory wait cycles.

Reset
REQ-033 With i_rst high at a clock edge: state=RESET, level=0, fault=0, irq_pending=0, previous-irq=0; all outputs 0 during RESET.
REQ-034 i_rst mid-access SHALL abandon the access; o_mem_req SHALL be 0 the cycle after.
REQ-035 Reset SHALL be the only exit from HALT and the only clear of o_stack_fault.

Verification
REQ-036 Reset: i_rst=1 for 2 cycles mid-LOAD -> all outputs 0, level=0; after release cmd sequence 0,1,2,3.
REQ-037 NOP, ready=1 -> cmds 1,2,3,0 then 1; exactly one o_inc_pc.
REQ-038 LOAD, ready low 2 cycles on every access -> OP_RD and MEM_RD each last 3 cycles; o_inc_pc=2 total; WB_MD cmd 5.
REQ-039 16 PUSHes then PUSH -> level 16, 17th sets o_stack_fault=1, o_halted=1, no cmd 9 issued.
REQ-040 POP at level 0 -> fault=1, HALT; following class inputs ignored until reset.
REQ-041 i_irq rises during ALU, held high -> after WB_R cmds 7,F,9 then o_irq_ack=1 one cycle, level+1; no second entry until i_irq drops and rises again.
